// File: rtl/seven_seg_capture_if.sv
// Bus bundle for the seven-segment capture block: the multiplexed display
// lines coming in, and the captured frame leaving through a valid/ready handshake.
// The slave modport is the capture block. The master modport is whoever drives
// the display lines and consumes frames.
`timescale 1ns/1ps
interface seven_seg_capture_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   an_in;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_err;
  logic                valid;
  logic                ready;
  logic                overrun;

  modport master (
    output seg_in, an_in, ready,
    input  value, digit_err, valid, overrun
  );

  modport slave (
    input  seg_in, an_in, ready,
    output value, digit_err, valid, overrun
  );
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: samples a multiplexed active-low seven-segment bus.
// Each digit is accepted once its {an_in, seg_in} pattern has been stable for
// STABLE_CYCLES samples. The pattern is decoded back to a nibble, and the
// nibbles are collected into one frame per full set of digits. Each frame is
// offered downstream through valid/ready. If a frame completes while the
// previous one has not been taken, the new frame is dropped and the sticky
// overrun flag is set.
// Optional macro SEVEN_SEG_CAP_SYNC_EN: passes the pins through a 2-flop
// synchronizer before sampling. This adds 2 cycles of input latency.
`timescale 1ns/1ps
module seven_seg_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst_n,
  seven_seg_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = DIGITS + 7;
  localparam logic [CW-1:0] COUNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

  // {err, nibble}; anything that is not a hex glyph reports nibble 0 with err set
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

  logic [DIGITS-1:0] an_s;
  logic [6:0]        seg_s;

`ifdef SEVEN_SEG_CAP_SYNC_EN
  logic [SW-1:0] sync_a_reg, sync_b_reg;

  // Two-flop synchronizer. It resets to the idle (all-high) bus pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a_reg <= '1;
      sync_b_reg <= '1;
    end else begin
      sync_a_reg <= {bus.an_in, bus.seg_in};
      sync_b_reg <= sync_a_reg;
    end
  end

  assign an_s  = sync_b_reg[SW-1:7];
  assign seg_s = sync_b_reg[6:0];
`else
  assign an_s  = bus.an_in;
  assign seg_s = bus.seg_in;
`endif

  state_t              state_reg, state_next;
  logic [CW-1:0]       count_reg, count_next, count_inc;
  logic [SW-1:0]       latched_reg;
  logic [4*DIGITS-1:0] frame_reg, frame_merge, value_reg;
  logic [DIGITS-1:0]   ferr_reg, ferr_merge, err_reg;
  logic [DIGITS-1:0]   mask_reg, mask_merge;
  logic                valid_reg, overrun_reg;

  logic [SW-1:0]     sample;
  logic [DIGITS-1:0] sel;
  logic              legal, same, latch_en, capture, complete, accept;
  logic [4:0]        decoded;

  assign sample  = {an_s, seg_s};
  assign sel     = ~an_s;
  assign legal   = (sel != '0) && ((sel & (sel - DIGITS'(1))) == '0);
  assign same    = (sample == latched_reg);
  assign decoded = decode(seg_s);
  assign count_inc = (count_reg < COUNT_MAX) ? count_reg + CW'(1) : count_reg;

  // Next-state decision. The WAIT case also covers a changed sample in HOLD.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    latch_en   = 1'b0;
    capture    = 1'b0;
    if (state_reg == SETTLE && same) begin
      count_next = count_inc;
      if (count_inc == COUNT_MAX) begin
        capture    = 1'b1;
        state_next = HOLD;
      end
    end else if (!(state_reg == HOLD && same)) begin
      if (legal) begin
        latch_en   = 1'b1;
        count_next = CW'(1);
        if (STABLE_CYCLES == 1) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else begin
          state_next = SETTLE;
        end
      end else begin
        state_next = WAIT;
      end
    end
  end

  // Merge a capture into the frame buffer, one slot per digit select.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
    assign frame_merge[4*gi +: 4] = (capture && sel[gi]) ? decoded[3:0] : frame_reg[4*gi +: 4];
    assign ferr_merge[gi]         = (capture && sel[gi]) ? decoded[4]   : ferr_reg[gi];
  end

  assign mask_merge = mask_reg | (capture ? sel : '0);
  assign complete   = capture && (&mask_merge);
  assign accept     = valid_reg && bus.ready;

  // State, frame assembly and the output handshake are updated together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= WAIT;
      count_reg   <= '0;
      latched_reg <= '1;
      frame_reg   <= '0;
      ferr_reg    <= '0;
      mask_reg    <= '0;
      value_reg   <= '0;
      err_reg     <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (latch_en) latched_reg <= sample;
      frame_reg <= frame_merge;
      ferr_reg  <= ferr_merge;
      mask_reg  <= complete ? '0 : mask_merge;
      if (accept) begin
        valid_reg   <= 1'b0;
        overrun_reg <= 1'b0;
      end
      if (complete) begin
        if (!valid_reg || accept) begin
          value_reg <= frame_merge;
          err_reg   <= ferr_merge;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.value     = value_reg;
  assign bus.digit_err = err_reg;
  assign bus.valid     = valid_reg;
  assign bus.overrun   = overrun_reg;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Testbench for seven_seg_capture: directed scenarios plus a randomized run.
// The randomized run is checked against a behavioural model of the bus rules.
`timescale 1ns/1ps
module tb_seven_seg_capture;
  localparam int DIGITS = 4;
`ifdef SEVEN_SEG_CAP_SYNC_EN
  localparam int STABLE = 1;
`else
  localparam int STABLE = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  seven_seg_capture_if #(.DIGITS(DIGITS)) bus ();

  seven_seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input int n);
    case (n)
      0: glyph = 7'b1000000;  1: glyph = 7'b1111001;
      2: glyph = 7'b0100100;  3: glyph = 7'b0110000;
      4: glyph = 7'b0011001;  5: glyph = 7'b0010010;
      6: glyph = 7'b0000010;  7: glyph = 7'b1111000;
      8: glyph = 7'b0000000;  9: glyph = 7'b0010000;
      10: glyph = 7'b0001000; 11: glyph = 7'b0000011;
      12: glyph = 7'b1000110; 13: glyph = 7'b0100001;
      14: glyph = 7'b0000110; 15: glyph = 7'b0001110;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Reference model. A legal sample that has been seen for exactly STABLE
  // consecutive cycles is captured once. Frames follow the handshake rules.
  logic [10:0] m_prev;
  bit          m_have;
  int          m_run;
  logic [15:0] m_buf, m_value;
  logic [3:0]  m_ebuf, m_err, m_mask;
  bit          m_valid, m_over;
`ifdef SEVEN_SEG_CAP_SYNC_EN
  logic [10:0] m_pipe [2];
`endif

  always @(posedge clk) begin : model
    logic [10:0] s;
    logic [3:0]  act;
    int idx, nib;
    bit bad;
    if (!rst_n) begin
      m_have = 0; m_run = 0; m_prev = '1;
      m_buf = '0; m_ebuf = '0; m_mask = '0;
      m_value = '0; m_err = '0; m_valid = 0; m_over = 0;
`ifdef SEVEN_SEG_CAP_SYNC_EN
      m_pipe[0] = '1; m_pipe[1] = '1;
`endif
    end else begin
`ifdef SEVEN_SEG_CAP_SYNC_EN
      s = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = {bus.an_in, bus.seg_in};
`else
      s = {bus.an_in, bus.seg_in};
`endif
      if (m_have && s == m_prev) begin
        if (m_run <= STABLE) m_run++;
      end else begin
        m_run = 1;
      end
      m_prev = s;
      m_have = 1;
      if (m_valid && bus.ready) begin
        m_valid = 0;
        m_over = 0;
      end
      act = ~s[10:7];
      if ($countones(act) == 1 && m_run == STABLE) begin
        idx = 0;
        for (int k = 0; k < DIGITS; k++) if (act[k]) idx = k;
        nib = 0; bad = 1;
        for (int k = 0; k < 16; k++) if (glyph(k) == s[6:0]) begin nib = k; bad = 0; end
        m_buf[4*idx +: 4] = 4'(nib);
        m_ebuf[idx] = bad;
        m_mask[idx] = 1'b1;
        if (m_mask == 4'hF) begin
          if (!m_valid) begin
            m_value = m_buf; m_err = m_ebuf; m_valid = 1;
          end else begin
            m_over = 1;
          end
          m_mask = '0;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    bus.an_in = an;
    bus.seg_in = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_digit(input int d, input int n);
    drive(~(4'(1) << d), glyph(n), STABLE);
  endtask

  task automatic test_reset();
    rst_n = 0; bus.ready = 1; bus.an_in = '1; bus.seg_in = '1;
    repeat (2) @(negedge clk);
    checks++; if (bus.value !== 16'h0) begin errors++; $display("FAIL reset_value got %h want 0000", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL reset_err got %b want 0000", bus.digit_err); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
    $display("test_reset done");
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    bus.ready = 1;
    drive_digit(0, 2); drive_digit(1, 3); drive_digit(2, 4); drive_digit(3, 5);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h5432) begin errors++; $display("FAIL basic_value got %h want 5432", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL basic_err got %b want 0000", bus.digit_err); end
    drive(4'hF, 7'h7F, 1);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", bus.valid); end
    $display("test_basic_frame value=%h", bus.value);
  endtask

  task automatic test_settle_restart();
    bus.ready = 1;
    drive_digit(1, 7); drive_digit(2, 8); drive_digit(3, 9);
    drive(4'b1110, 7'b1111001, 3);
    drive(4'b1110, 7'b1000000, 3);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL settle_early got %b want 0", bus.valid); end
    drive(4'b1110, 7'b1000000, 1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL settle_valid got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h9870) begin errors++; $display("FAIL settle_value got %h want 9870", bus.value); end
    drive(4'hF, 7'h7F, 1);
    $display("test_settle_restart value=%h", bus.value);
  endtask

  task automatic test_illegal_glyph();
    bus.ready = 1;
    drive_digit(0, 10); drive_digit(1, 11);
    drive(4'b1011, 7'b1111111, STABLE);
    drive_digit(3, 12);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL illegal_valid got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'hC0BA) begin errors++; $display("FAIL illegal_value got %h want c0ba", bus.value); end
    checks++; if (bus.digit_err !== 4'b0100) begin errors++; $display("FAIL illegal_err got %b want 0100", bus.digit_err); end
    drive(4'hF, 7'h7F, 1);
    $display("test_illegal_glyph err=%b", bus.digit_err);
  endtask

  task automatic test_idle_select();
    bus.ready = 1;
    drive_digit(0, 1); drive_digit(1, 2); drive_digit(2, 3);
    drive(4'b1100, glyph(14), 10);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", bus.valid); end
    drive_digit(3, 4);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL idle_frame got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h4321) begin errors++; $display("FAIL idle_value got %h want 4321", bus.value); end
    drive(4'hF, 7'h7F, 1);
    $display("test_idle_select value=%h", bus.value);
  endtask

  task automatic test_backpressure();
    bus.ready = 0;
    drive_digit(0, 6); drive_digit(1, 7); drive_digit(2, 8); drive_digit(3, 9);
    checks++; if (bus.value !== 16'h9876) begin errors++; $display("FAIL bp_first got %h want 9876", bus.value); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL bp_no_overrun got %b want 0", bus.overrun); end
    drive_digit(0, 1); drive_digit(1, 2); drive_digit(2, 3); drive_digit(3, 4);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h9876) begin errors++; $display("FAIL bp_held got %h want 9876", bus.value); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b want 1", bus.overrun); end
    bus.ready = 1;
    drive(4'hF, 7'h7F, 1);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b want 0", bus.valid); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL bp_clear got %b want 0", bus.overrun); end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_frame();
    bus.ready = 1;
    drive_digit(0, 13); drive_digit(1, 14);
    rst_n = 0;
    drive(4'hF, 7'h7F, 1);
    checks++; if (bus.value !== 16'h0) begin errors++; $display("FAIL rst_value got %h want 0000", bus.value); end
    checks++; if (bus.digit_err !== 4'h0) begin errors++; $display("FAIL rst_err got %b want 0000", bus.digit_err); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid); end
    rst_n = 1;
    drive_digit(2, 15); drive_digit(3, 1); drive_digit(0, 2);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL rst_partial got %b want 0", bus.valid); end
    drive_digit(1, 3);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rst_refill got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h1F32) begin errors++; $display("FAIL rst_frame got %h want 1f32", bus.value); end
    drive(4'hF, 7'h7F, 1);
    $display("test_reset_mid_frame value=%h", bus.value);
  endtask

  task automatic test_sync_latency();
    bus.ready = 1;
    drive_digit(0, 5); drive_digit(1, 6); drive_digit(2, 7);
    drive(4'b0111, glyph(8), 2);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL sync_early got %b want 0", bus.valid); end
    drive(4'b0111, glyph(8), 1);
    checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL sync_valid got %b want 1", bus.valid); end
    checks++; if (bus.value !== 16'h8765) begin errors++; $display("FAIL sync_value got %h want 8765", bus.value); end
    drive(4'hF, 7'h7F, 3);
    $display("test_sync_latency value=%h", bus.value);
  endtask

  task automatic test_random();
    logic [3:0] an;
    logic [6:0] seg;
    int kind, len;
    for (int t = 0; t < 250; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7) an = ~(4'(1) << $urandom_range(0, 3));
      else if (kind == 7) an = 4'hF;
      else an = 4'($urandom);
      seg = ($urandom_range(0, 9) == 0) ? 7'($urandom) : glyph(int'($urandom_range(0, 15)));
      len = int'($urandom_range(1, 7));
      bus.an_in = an;
      bus.seg_in = seg;
      for (int c = 0; c < len; c++) begin
        bus.ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL rand_valid t=%0d got %b want %b", t, bus.valid, m_valid); end
        checks++; if (bus.value !== m_value) begin errors++; $display("FAIL rand_value t=%0d got %h want %h", t, bus.value, m_value); end
        checks++; if (bus.digit_err !== m_err) begin errors++; $display("FAIL rand_err t=%0d got %b want %b", t, bus.digit_err, m_err); end
        checks++; if (bus.overrun !== m_over) begin errors++; $display("FAIL rand_overrun t=%0d got %b want %b", t, bus.overrun, m_over); end
      end
    end
    bus.ready = 1;
    $display("test_random done");
  endtask

  initial begin
    bus.an_in = '1;
    bus.seg_in = '1;
    bus.ready = 1;
    test_reset();
`ifdef SEVEN_SEG_CAP_SYNC_EN
    test_sync_latency();
`else
    test_basic_frame();
    test_settle_restart();
    test_illegal_glyph();
    test_idle_select();
    test_backpressure();
    test_reset_mid_frame();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the hex-to-segment encoder. It samples a multiplexed, active-low seven-segment display bus (segment lines plus per-digit anode selects), waits for each digit's pattern to be stable, and decodes it back to a hex nibble. It assembles one nibble per digit into a frame and hands the frame downstream with a valid/ready handshake. The block sits between a scanned display driver, or an external display bus, and the self-check or logging logic.

## Interface
- `DIGITS`, 4: number of multiplexed digits; minimum 1.
- `STABLE_CYCLES`, 4: consecutive identical samples required before a digit is accepted; minimum 1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `seg_in` in 7: segment lines, active-low; bit 0 is segment a, bit 6 is segment g.
- `an_in` in DIGITS: digit selects, active-low; exactly one bit low selects a digit.
- `value` out 4*DIGITS: captured frame; digit i occupies `[4i+3:4i]`.
- `digit_err` out DIGITS: bit i is 1 when digit i's pattern was not a legal hex glyph.
- `valid` out 1: frame available.
- `ready` in 1: downstream accepts the frame.
- `overrun` out 1: sticky; a completed frame was dropped because the previous one was not yet taken.

## Operation
- **Sample definition:** a sample is the pair `{an_in, seg_in}` as seen by the capture logic. With `SEVEN_SEG_CAP_SYNC_EN` defined, this is the synchronizer output.
- **Legal select:** `an_in` has exactly one bit low. All-high, or more than one bit low, is idle.
- **Decode table** (`seg_in[6:0]` → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→b
  - 1000110→C, 0100001→d, 0000110→E, 0001110→F
  - Any other pattern, including 1111111, decodes to nibble 0 with the error bit set.
- **State `WAIT`:** idle select.
  - Legal select → `SETTLE`. Latch the sample, count=1.
  - If STABLE_CYCLES=1, capture immediately and go to `HOLD`.
- **State `SETTLE`:**
  - Sample equals the latched sample: increment count. When count reaches STABLE_CYCLES, capture and go to `HOLD`.
  - Sample differs and the select is legal: relatch, count=1.
  - Sample differs and the select is idle: go to `WAIT`.
- **State `HOLD`:**
  - Unchanged sample: stay, no further capture.
  - Any change: evaluate exactly as from `WAIT`.
- **Capture:**
  - Write the nibble to the frame buffer slot for the low `an_in` bit, and write that slot's error bit.
  - Set the slot's bit in the frame mask.
  - Re-capturing a digit already in the mask overwrites the slot; the mask bit is unchanged.
- **Frame complete:** the mask becomes all ones on a capture edge.
  - If `valid`=0, or `valid`&`ready` on that same edge: load `value` and `digit_err` from the buffer (including the just-captured nibble) and set `valid`=1.
  - Otherwise: drop the frame and set `overrun`=1.
  - The mask clears in both cases.
- **Handshake:**
  - `valid` is held with `value` and `digit_err` stable until `valid`&`ready`.
  - On the accept edge, `valid` falls and `overrun` clears, unless a new frame loads on that same edge; in that case `valid` stays 1.
  - `ready` while `valid`=0 has no effect.
- **Count:** width clog2(STABLE_CYCLES+1). The counter saturates and never wraps.

## Timing
- **Reset values:** `value`=0, `digit_err`=0, `valid`=0, `overrun`=0, state `WAIT`, mask 0, count 0.
- **Reset mid-operation:** discards the partial frame and any pending frame.
- **Capture latency:** a new legal sample first seen at edge e0 and unchanged through edge e(STABLE_CYCLES−1) is captured at edge e(STABLE_CYCLES−1).
- **Valid latency:** if that capture completes the frame, `valid` is high after the same edge. There is no additional pipeline cycle.
- **Sync latency:** with the synchronizer, add 2 cycles from the pins to the sample.
- **Output stability:** outputs change only on clock edges.

## Configuration
- **`SEVEN_SEG_CAP_SYNC_EN` defined:** `seg_in` and `an_in` pass through a 2-flop synchronizer, reset to all-ones. Input-to-capture latency is STABLE_CYCLES+2.
- **`SEVEN_SEG_CAP_SYNC_EN` undefined:** pins are sampled directly. Inputs must then be synchronous to `clk`.

## Test plan
Defaults DIGITS=4 and STABLE_CYCLES=4, macro undefined, unless a line says otherwise.
- **Basic frame:** `ready`=1; hold an_in=1110/seg=0100100, then 1101/0110000, 1011/0011001, 0111/0010010, 4 cycles each → `value`=16'h5432, `digit_err`=0, one `valid` pulse.
- **Settle restart:** an_in=1110, seg=1111001 for 3 cycles, then 1000000 for 4 cycles → slot 0 = 0 (not 1); capture on the 4th cycle of 1000000.
- **Illegal glyph and idle select:** seg=1111111 on digit 2 → `digit_err`=4'b0100 and nibble 0. Separately, an_in=1100 for 10 cycles → no capture, state `WAIT`.
- **Backpressure:** `ready`=0 across two complete frames → first frame held unchanged, `overrun`=1. Then `ready`=1 for one cycle → `valid`=0, `overrun`=0.
- **Reset mid-frame:** rst_n=0 for 1 cycle after 2 digits are captured → all outputs 0. Next `valid` only after all 4 digits are re-captured.
- **Synchronizer latency:** macro defined, STABLE_CYCLES=1 → capture 3 cycles after the pin change.
